// File: rtl/t_flip_flop_counter_pkg.sv
// Shared types and helpers for the T-stage modulo-N counter.
// Holds direction encodings and the non-wrap toggle mask.
package t_flip_flop_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  localparam int   MAX_W    = 16;

  // Stage i toggles when every lower stage is 1 (up) or 0 (down).
  function automatic logic [MAX_W-1:0] toggle_mask(
    input logic [MAX_W-1:0] q,
    input logic             up,
    input logic             en
  );
    logic [MAX_W-1:0] m;
    logic             run;
    m   = '0;
    run = en;
    for (int i = 0; i < MAX_W; i++) begin
      m[i] = run;
      run  = run & ((up == DIR_UP) ? q[i] : ~q[i]);
    end
    return m;
  endfunction

endpackage

// File: rtl/t_flip_flop_counter_t_stage.sv
// Single toggle flip-flop with synchronous active-high reset.
// One copy per count bit; the parent computes its toggle input.
module t_stage (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;

  // Toggle on t, clear on reset.
  always_ff @(posedge clk) begin
    if (rst) r_q <= 1'b0;
    else     r_q <= r_q ^ t;
  end

  assign q = r_q;

endmodule

// File: rtl/t_flip_flop_counter.sv
// Modulo-N up/down counter built from a chain of T stages.
// Optional parallel load: define T_FLIP_FLOP_COUNTER_LOAD_EN.
module t_flip_flop_counter
  import t_flip_flop_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] t,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAXV  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_t;
  logic [WIDTH-1:0] w_t_nat;
  logic [WIDTH-1:0] w_target;
  logic [WIDTH-1:0] w_ld_val;
  logic             w_load;
  logic             w_tc;
  logic             r_wrap;

`ifdef T_FLIP_FLOP_COUNTER_LOAD_EN
  assign w_load   = load;
  assign w_ld_val = ({1'b0, d} >= MOD_W) ? MAXV : d;
`else
  logic w_unused_ld;
  assign w_unused_ld = ^{load, d, MOD_W};
  assign w_load      = 1'b0;
  assign w_ld_val    = '0;
`endif

  assign w_t_nat  = WIDTH'(toggle_mask(MAX_W'(w_q), up, en));
  assign w_target = (up == DIR_DOWN) ? MAXV : '0;
  assign w_tc     = en & ((up == DIR_UP) ? (w_q == MAXV)
                                         : (w_q == '0));

  // Load overrides wrap, wrap overrides the natural carry chain.
  always_comb begin
    w_t = w_t_nat;
    if (w_load)    w_t = w_q ^ w_ld_val;
    else if (w_tc) w_t = w_q ^ w_target;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    t_stage u_stage (
      .clk (clk),
      .rst (rst),
      .t   (w_t[i]),
      .q   (w_q[i])
    );
  end

  // Wrap pulse follows tc unless reset or load claims the edge.
  always_ff @(posedge clk) begin
    if (rst || w_load) r_wrap <= 1'b0;
    else               r_wrap <= w_tc;
  end

  assign q    = w_q;
  assign t    = w_t;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_t_flip_flop_counter.sv
// Directed vector bench for t_flip_flop_counter (WIDTH=4, MODULUS=10).
// Load scenarios follow T_FLIP_FLOP_COUNTER_LOAD_EN.
module tb_t_flip_flop_counter;

  logic       clk = 1'b0;
  logic       rst, en, up, load;
  logic [3:0] d, q, t;
  logic       tc, wrap;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       rst, en, up;
    logic [3:0] q, t;
    logic       tc, wrap;
  } vec_t;

  vec_t tv[$];

  t_flip_flop_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .up   (up),
    .load (load),
    .d    (d),
    .q    (q),
    .t    (t),
    .tc   (tc),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic r, e, u,
    input logic [3:0] qq, tt,
    input logic c, w
  );
    vec_t v;
    v.rst = r; v.en = e; v.up = u;
    v.q = qq; v.t = tt; v.tc = c; v.wrap = w;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq,
                         input logic [3:0] et, input logic etc,
                         input logic ew);
    chk({tag, ".q"},    int'(q),    int'(eq));
    chk({tag, ".t"},    int'(t),    int'(et));
    chk({tag, ".tc"},   int'(tc),   int'(etc));
    chk({tag, ".wrap"}, int'(wrap), int'(ew));
  endtask

  task automatic drive(input logic r, e, u, l, input logic [3:0] dd);
    rst = r; en = e; up = u; load = l; d = dd;
  endtask

  initial begin
    // reset (2 cycles), up count 0..9 wrap to 0,1,2
    tv.push_back(mk(1, 1, 1, 4'd0, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd0, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd1, 4'b0011, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd2, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd3, 4'b0111, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd4, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd5, 4'b0011, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd6, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd7, 4'b1111, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd8, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd9, 4'b1001, 1, 0));
    tv.push_back(mk(0, 1, 1, 4'd0, 4'b0001, 0, 1));
    tv.push_back(mk(0, 1, 1, 4'd1, 4'b0011, 0, 0));
    // reset then down wrap 0 -> 9,8,7,6
    tv.push_back(mk(1, 1, 1, 4'd2, 4'b0001, 0, 0));
    tv.push_back(mk(0, 1, 0, 4'd0, 4'b1001, 1, 0));
    tv.push_back(mk(0, 1, 0, 4'd9, 4'b0001, 0, 1));
    tv.push_back(mk(0, 1, 0, 4'd8, 4'b1111, 0, 0));
    tv.push_back(mk(0, 1, 0, 4'd7, 4'b0001, 0, 0));
    // enable gating at 6
    tv.push_back(mk(0, 0, 0, 4'd6, 4'b0000, 0, 0));
    tv.push_back(mk(0, 0, 0, 4'd6, 4'b0000, 0, 0));
    tv.push_back(mk(0, 0, 1, 4'd6, 4'b0000, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd6, 4'b0001, 0, 0));
    // direction change 7->8->7->8->9
    tv.push_back(mk(0, 1, 1, 4'd7, 4'b1111, 0, 0));
    tv.push_back(mk(0, 1, 0, 4'd8, 4'b1111, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd7, 4'b1111, 0, 0));
    tv.push_back(mk(0, 1, 1, 4'd8, 4'b0001, 0, 0));
    // reset coincident with tc: no wrap pulse
    tv.push_back(mk(1, 1, 1, 4'd9, 4'b1001, 1, 0));
    tv.push_back(mk(0, 0, 1, 4'd0, 4'b0000, 0, 0));

    drive(1, 1, 1, 0, 4'd0);
    @(negedge clk);
    @(negedge clk);
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].en, tv[k].up, 1'b0, 4'd0);
      #1;
      chk_all($sformatf("vec%0d", k), tv[k].q, tv[k].t,
              tv[k].tc, tv[k].wrap);
      @(negedge clk);
    end

    // q is 0 here, en was 0
`ifdef T_FLIP_FLOP_COUNTER_LOAD_EN
    drive(0, 0, 1, 1, 4'd3);
    #1;
    chk("ld3.t", int'(t), 3);
    @(negedge clk);
    drive(0, 0, 1, 1, 4'd14);
    #1;
    chk("ld3.q", int'(q), 3);
    chk("ld14.t", int'(t), 10);
    @(negedge clk);
    drive(0, 1, 1, 1, 4'd5);
    #1;
    chk("ld14.q", int'(q), 9);
    chk("ldtc.tc", int'(tc), 1);
    chk("ldtc.t", int'(t), 12);
    @(negedge clk);
    drive(1, 1, 1, 1, 4'd7);
    #1;
    chk("ldtc.q", int'(q), 5);
    chk("ldtc.wrap", int'(wrap), 0);
    @(negedge clk);
    drive(0, 0, 1, 0, 4'd0);
    #1;
    chk("ldrst.q", int'(q), 0);
    chk("ldrst.wrap", int'(wrap), 0);
    @(negedge clk);
`else
    drive(0, 1, 1, 1, 4'd3);
    #1;
    chk("noload.t", int'(t), 1);
    @(negedge clk);
    drive(0, 0, 1, 1, 4'd14);
    #1;
    chk("noload.q", int'(q), 1);
    chk("noload.t0", int'(t), 0);
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
